regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 64: register and bus width in bits.
REQ-002 Parameter NUM_REGS, default 32: register count; SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_W, default $clog2(NUM_REGS): register address width.
REQ-004 Clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 RA, RB  in  ADDR_W  read addresses for ports A and B.
REQ-007 BusA, BusB  out  DATA_W  combinational read data for ports A and B.
REQ-008 ValidA, ValidB  out  1  addressed register has no outstanding pending write.
REQ-009 RW  in  ADDR_W  write address.
REQ-010 BusW  in  DATA_W  write data.
REQ-011 RegWr  in  1  write enable.
REQ-012 MarkEn  in  1  request to reserve register MarkReg as the destination of an in-flight producer.
REQ-013 MarkReg  in  ADDR_W  register to reserve.
REQ-014 MarkAck  out  1  combinational grant of the current MarkEn request.
REQ-015 PendCount  out  ADDR_W+1  registered number of pending bits currently set.

Function
REQ-016 Register NUM_REGS-1 (ZR) SHALL read as 0, SHALL never be written, and SHALL never become pending.
REQ-017 Reads SHALL be combinational with zero-cycle latency: BusA = reg[RA], BusB = reg[RB].
REQ-018 When RegWr=1, Reset=0 and RW!=ZR, reg[RW] SHALL be updated with BusW at the rising edge and SHALL be visible on BusA/BusB in the following cycle.
REQ-019 A write to reg[RW] SHALL clear pending[RW], whether or not the bit was set.
REQ-020 MarkAck SHALL be 1 iff MarkEn=1, Reset=0, and at least one of the following holds: pending[MarkReg]=0; RegWr=1 with RW==MarkReg in the same cycle; MarkReg==ZR.
REQ-021 When MarkAck=1 and MarkReg!=ZR, pending[MarkReg] SHALL be set at the edge.
REQ-022 If a write and an acknowledged mark target the same register in the same cycle, the data SHALL be written and pending SHALL end set (mark wins).
REQ-023 A refused mark (MarkEn=1, MarkAck=0) SHALL change no state; the requester holds MarkEn/MarkReg and retries.
REQ-024 ValidA/ValidB SHALL equal the inverse of pending[RA]/pending[RB]; ZR is always valid.
REQ-025 PendCount SHALL equal the number of set pending bits after each edge (range 0..NUM_REGS-1).
REQ-026 PendCount SHALL be maintained as an up/down counter, not a popcount: +1 for each newly set bit, -1 for each newly cleared bit, no change when both occur.

Reset
REQ-027 While Reset=1, at the rising edge all registers SHALL become 0, all pending bits 0, and PendCount 0.
REQ-028 While Reset=1, MarkAck SHALL be 0 and RegWr SHALL be ignored.
REQ-029 A reset asserted mid-operation SHALL discard all pending reservations; no write SHALL be retained from the reset cycle.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN, when defined: if RegWr=1, RW!=ZR, and RA==RW (or RB==RW), BusA (BusB) SHALL return BusW in the same cycle, and ValidA (ValidB) SHALL be 1.
REQ-031 Without REGFILE_BYPASS_EN: reads SHALL return the stored value, and Valid SHALL reflect the stored pending bit only.

Verification
REQ-032 Reset, then write reg[i]=i for i=0..31 with RegWr=1, then read RA=2, RB=3 -> BusA=2, BusB=3; RA=31 -> BusA=0.
REQ-033 RegWr=0, RW=1, BusW=1000 for one edge -> reg[1] still reads 1.
REQ-034 MarkEn=1, MarkReg=5 -> MarkAck=1; next cycle RB=5 -> ValidB=0, PendCount=1; a second MarkEn on 5 -> MarkAck=0; then RegWr=1, RW=5, BusW=0xABCD -> next cycle BusB=0xABCD, ValidB=1, PendCount=0.
REQ-035 In one cycle: pending[7]=1, RegWr=1, RW=7, MarkEn=1, MarkReg=7 -> MarkAck=1; afterwards reg[7]=new data, ValidA(RA=7)=0, PendCount unchanged.
REQ-036 With REGFILE_BYPASS_EN: RA=RW=0xC, RegWr=1, BusW=0x9080009 -> BusA=0x9080009 in the same cycle. Without the macro -> BusA=0xC in that cycle and 0x9080009 in the next.
REQ-037 Mark registers 1..3, then assert Reset for one edge -> PendCount=0, all Valid=1, all registers read 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Multi-ported register file with a per-register pending
//            (scoreboard) bit. Two combinational read ports, one write port
//            and one mark (reservation) port. The highest register (ZR)
//            always reads zero, ignores writes and is never pending.
//            PendCount tracks the number of set pending bits as an up/down
//            counter.
// Config   : `define REGFILE_BYPASS_EN to forward same-cycle write data
//            (and validity) to a read port whose address matches RW.
//            Without it, reads return stored state only.
// Ports    : clk_i          - clock, rising edge
//            reset_i        - synchronous, active-high reset
//            ra_i / rb_i    - read addresses, ports A / B
//            bus_a_o/bus_b_o- combinational read data
//            valid_a_o/_b_o - addressed register has no pending write
//            rw_i, bus_w_i, reg_wr_i - write address / data / enable
//            mark_en_i, mark_reg_i   - reservation request / target
//            mark_ack_o     - combinational grant of the reservation
//            pend_count_o   - registered count of pending bits
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  output logic [DATA_W-1:0] bus_a_o,
  output logic [DATA_W-1:0] bus_b_o,
  output logic              valid_a_o,
  output logic              valid_b_o,
  input  logic [ADDR_W-1:0] rw_i,
  input  logic [DATA_W-1:0] bus_w_i,
  input  logic              reg_wr_i,
  input  logic              mark_en_i,
  input  logic [ADDR_W-1:0] mark_reg_i,
  output logic              mark_ack_o,
  output logic [ADDR_W:0]   pend_count_o
);

  // Elaboration-time sanity check of the configuration.
  if ((NUM_REGS < 4) || ((NUM_REGS & (NUM_REGS - 1)) != 0) ||
      (ADDR_W != $clog2(NUM_REGS))) begin : g_bad_params
    $error("regfile_scoreboard: NUM_REGS must be a power of two >= 4 and ADDR_W = clog2(NUM_REGS)");
  end

  // ZR is the last register; NUM_REGS is a power of two so it is all ones.
  localparam logic [ADDR_W-1:0] c_zr      = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   c_cnt_one = {{ADDR_W{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [ADDR_W:0]     pend_cnt_q;
  logic [ADDR_W:0]     pend_cnt_d;

  // --------------------------------------------------------------------------
  // Write / mark qualification
  // --------------------------------------------------------------------------
  logic w_wr_en;       // effective write this cycle
  logic w_wr_hits_mark; // write and mark target the same register
  logic w_mark_ack;
  logic w_mark_set;    // acknowledged mark that actually sets a bit
  logic w_newly_set;
  logic w_newly_clr;

  assign w_wr_en        = reg_wr_i && !reset_i && (rw_i != c_zr);
  assign w_wr_hits_mark = reg_wr_i && (rw_i == mark_reg_i);

  // A pending register may be re-reserved only when its producer is
  // retiring in this same cycle; ZR reservations are granted but ignored.
  assign w_mark_ack = mark_en_i && !reset_i &&
                      (!pending_q[mark_reg_i] || w_wr_hits_mark ||
                       (mark_reg_i == c_zr));
  assign w_mark_set = w_mark_ack && (mark_reg_i != c_zr);

  assign mark_ack_o = w_mark_ack;

  // Counter deltas. A mark on a register already pending (same-cycle write
  // case) leaves the bit set, so it is neither a set nor a clear. A write
  // only clears if the bit was set and the mark does not re-set it.
  assign w_newly_set = w_mark_set && !pending_q[mark_reg_i];
  assign w_newly_clr = w_wr_en && pending_q[rw_i] &&
                       !(w_mark_set && (mark_reg_i == rw_i));

  always_comb begin
    pending_d = pending_q;
    if (w_wr_en) begin
      pending_d[rw_i] = 1'b0;
    end
    // Applied after the clear so that the mark wins on a collision.
    if (w_mark_set) begin
      pending_d[mark_reg_i] = 1'b1;
    end
  end

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    case ({w_newly_set, w_newly_clr})
      2'b10:   pend_cnt_d = pend_cnt_q + c_cnt_one;
      2'b01:   pend_cnt_d = pend_cnt_q - c_cnt_one;
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (w_wr_en) begin
        regs_q[rw_i] <= bus_w_i;
      end
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_count_o = pend_cnt_q;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic w_byp_a;
  logic w_byp_b;

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write to a matching read port.
  assign w_byp_a = w_wr_en && (ra_i == rw_i);
  assign w_byp_b = w_wr_en && (rb_i == rw_i);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  // ZR is forced to zero on the read side as well, so it reads zero even
  // before the first reset.
  always_comb begin
    bus_a_o = '0;
    if (w_byp_a) begin
      bus_a_o = bus_w_i;
    end else if (ra_i != c_zr) begin
      bus_a_o = regs_q[ra_i];
    end
  end

  always_comb begin
    bus_b_o = '0;
    if (w_byp_b) begin
      bus_b_o = bus_w_i;
    end else if (rb_i != c_zr) begin
      bus_b_o = regs_q[rb_i];
    end
  end

  // pending[ZR] is never set, so ZR is always valid.
  assign valid_a_o = w_byp_a || !pending_q[ra_i];
  assign valid_b_o = w_byp_b || !pending_q[rb_i];

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Scoreboard bench for regfile_scoreboard. The stimulus process
//            drives directed vectors and queues hand-computed expectations
//            tagged with the cycle they apply to; a monitor process samples
//            the DUT on the falling edge and retires matching entries.
//            Expectations follow REGFILE_BYPASS_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  localparam int SEL_BA  = 0;
  localparam int SEL_BB  = 1;
  localparam int SEL_VA  = 2;
  localparam int SEL_VB  = 3;
  localparam int SEL_ACK = 4;
  localparam int SEL_PC  = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [AW-1:0] ra_i, rb_i, rw_i, mark_reg_i;
  logic [DW-1:0] bus_a_o, bus_b_o, bus_w_i;
  logic          valid_a_o, valid_b_o, reg_wr_i, mark_en_i, mark_ack_o;
  logic [AW:0]   pend_count_o;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .ADDR_W   (AW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .ra_i         (ra_i),
    .rb_i         (rb_i),
    .bus_a_o      (bus_a_o),
    .bus_b_o      (bus_b_o),
    .valid_a_o    (valid_a_o),
    .valid_b_o    (valid_b_o),
    .rw_i         (rw_i),
    .bus_w_i      (bus_w_i),
    .reg_wr_i     (reg_wr_i),
    .mark_en_i    (mark_en_i),
    .mark_reg_i   (mark_reg_i),
    .mark_ack_o   (mark_ack_o),
    .pend_count_o (pend_count_o)
  );

  typedef struct {
    string         name;
    int            sel;
    logic [DW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int sel, input logic [DW-1:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  function automatic logic [DW-1:0] actual(input int sel);
    case (sel)
      SEL_BA:  return bus_a_o;
      SEL_BB:  return bus_b_o;
      SEL_VA:  return {{(DW-1){1'b0}}, valid_a_o};
      SEL_VB:  return {{(DW-1){1'b0}}, valid_b_o};
      SEL_ACK: return {{(DW-1){1'b0}}, mark_ack_o};
      default: return {{(DW-AW-1){1'b0}}, pend_count_o};
    endcase
  endfunction

  // Monitor: retire every expectation due in the current cycle.
  initial forever begin
    exp_t          e;
    logic [DW-1:0] act;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = actual(e.sel);
      n_checks++;
      if (e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  initial begin
    reset_i    = 1'b1;
    ra_i       = '0;
    rb_i       = '0;
    rw_i       = '0;
    bus_w_i    = '0;
    reg_wr_i   = 1'b0;
    mark_en_i  = 1'b1;
    mark_reg_i = 5'd2;
    step();

    // Still in reset: no grant, everything cleared.
    chk("rst_ack", SEL_ACK, 0);
    chk("rst_pc", SEL_PC, 0);
    chk("rst_busa", SEL_BA, 0);
    chk("rst_valida", SEL_VA, 1);
    reg_wr_i = 1'b1;
    rw_i     = 5'd3;
    bus_w_i  = 64'd99;
    step();

    reset_i   = 1'b0;
    reg_wr_i  = 1'b0;
    mark_en_i = 1'b0;
    ra_i      = 5'd3;
    chk("rst_write_dropped", SEL_BA, 0);

    // Fill reg[i] = i (ZR ignores its write).
    for (int i = 0; i < NR; i++) begin
      reg_wr_i = 1'b1;
      rw_i     = AW'(i);
      bus_w_i  = DW'(i);
      step();
    end
    reg_wr_i = 1'b0;
    ra_i = 5'd2;
    rb_i = 5'd3;
    chk("read_a2", SEL_BA, 2);
    chk("read_b3", SEL_BB, 3);
    step();
    ra_i = 5'd31;
    chk("read_zr", SEL_BA, 0);
    step();

    // Write enable low: no update.
    rw_i    = 5'd1;
    bus_w_i = 64'd1000;
    step();
    ra_i = 5'd1;
    chk("no_wr_reg1", SEL_BA, 1);

    // Reserve 5, refused re-reserve, then retire by write.
    mark_en_i  = 1'b1;
    mark_reg_i = 5'd5;
    rb_i       = 5'd5;
    chk("mark5_ack", SEL_ACK, 1);
    chk("mark5_pc_before", SEL_PC, 0);
    chk("mark5_validb_before", SEL_VB, 1);
    step();
    chk("mark5_refused", SEL_ACK, 0);
    chk("mark5_validb", SEL_VB, 0);
    chk("mark5_pc", SEL_PC, 1);
    step();
    mark_en_i = 1'b0;
    reg_wr_i  = 1'b1;
    rw_i      = 5'd5;
    bus_w_i   = 64'hABCD;
    chk("refused_no_change_pc", SEL_PC, 1);
    chk("wr5_busb_same_cycle", SEL_BB, BYP ? 64'hABCD : 64'd5);
    chk("wr5_validb_same_cycle", SEL_VB, BYP ? 1 : 0);
    step();
    reg_wr_i = 1'b0;
    chk("wr5_busb", SEL_BB, 64'hABCD);
    chk("wr5_validb", SEL_VB, 1);
    chk("wr5_pc", SEL_PC, 0);
    step();

    // Write and mark collide on a pending register: mark wins.
    mark_en_i  = 1'b1;
    mark_reg_i = 5'd7;
    chk("mark7_ack", SEL_ACK, 1);
    step();
    reg_wr_i = 1'b1;
    rw_i     = 5'd7;
    bus_w_i  = 64'h77;
    chk("collide7_ack", SEL_ACK, 1);
    chk("collide7_pc_before", SEL_PC, 1);
    step();
    mark_en_i = 1'b0;
    reg_wr_i  = 1'b0;
    ra_i      = 5'd7;
    chk("collide7_data", SEL_BA, 64'h77);
    chk("collide7_valida", SEL_VA, 0);
    chk("collide7_pc", SEL_PC, 1);
    step();

    // Write to a non-pending register leaves the count alone.
    reg_wr_i = 1'b1;
    rw_i     = 5'd8;
    bus_w_i  = 64'h88;
    step();
    reg_wr_i = 1'b0;
    ra_i     = 5'd8;
    chk("wr8_data", SEL_BA, 64'h88);
    chk("wr8_pc", SEL_PC, 1);
    step();

    // ZR: mark granted but ignored, write ignored.
    mark_en_i  = 1'b1;
    mark_reg_i = 5'd31;
    reg_wr_i   = 1'b1;
    rw_i       = 5'd31;
    bus_w_i    = 64'd55;
    ra_i       = 5'd31;
    chk("zr_mark_ack", SEL_ACK, 1);
    chk("zr_read_same_cycle", SEL_BA, 0);
    step();
    mark_en_i = 1'b0;
    reg_wr_i  = 1'b0;
    chk("zr_read", SEL_BA, 0);
    chk("zr_valid", SEL_VA, 1);
    chk("zr_pc", SEL_PC, 1);
    step();

    // Simultaneous new set (10) and clear (7): count unchanged.
    mark_en_i  = 1'b1;
    mark_reg_i = 5'd10;
    reg_wr_i   = 1'b1;
    rw_i       = 5'd7;
    bus_w_i    = 64'h70;
    chk("setclr_ack", SEL_ACK, 1);
    step();
    mark_en_i = 1'b0;
    reg_wr_i  = 1'b0;
    ra_i      = 5'd10;
    rb_i      = 5'd7;
    chk("setclr_valida10", SEL_VA, 0);
    chk("setclr_validb7", SEL_VB, 1);
    chk("setclr_busb7", SEL_BB, 64'h70);
    chk("setclr_pc", SEL_PC, 1);
    step();

    // Same-cycle read of a register being written.
    reg_wr_i = 1'b1;
    rw_i     = 5'd12;
    bus_w_i  = 64'h9080009;
    ra_i     = 5'd12;
    chk("byp_busa_same_cycle", SEL_BA, BYP ? 64'h9080009 : 64'hC);
    step();
    reg_wr_i = 1'b0;
    chk("byp_busa_next", SEL_BA, 64'h9080009);
    step();

    // Same-cycle validity of a pending register being written.
    reg_wr_i = 1'b1;
    rw_i     = 5'd10;
    bus_w_i  = 64'd5;
    ra_i     = 5'd10;
    chk("byp_valida_same_cycle", SEL_VA, BYP ? 1 : 0);
    step();
    reg_wr_i = 1'b0;
    chk("clear10_pc", SEL_PC, 0);
    chk("clear10_valida", SEL_VA, 1);
    step();

    // Mark 1..3, then reset mid-operation.
    mark_en_i = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      mark_reg_i = AW'(m);
      chk("mark123_ack", SEL_ACK, 1);
      step();
    end
    mark_en_i = 1'b0;
    ra_i      = 5'd2;
    chk("mark123_pc", SEL_PC, 3);
    chk("mark123_valida2", SEL_VA, 0);
    step();
    reset_i    = 1'b1;
    reg_wr_i   = 1'b1;
    rw_i       = 5'd4;
    bus_w_i    = 64'hDEAD;
    mark_en_i  = 1'b1;
    mark_reg_i = 5'd9;
    chk("reset_mark_ack", SEL_ACK, 0);
    step();
    reset_i   = 1'b0;
    reg_wr_i  = 1'b0;
    mark_en_i = 1'b0;
    chk("post_reset_pc", SEL_PC, 0);
    for (int i = 0; i < NR; i++) begin
      ra_i = AW'(i);
      rb_i = AW'(NR - 1 - i);
      chk("post_reset_busa", SEL_BA, 0);
      chk("post_reset_valida", SEL_VA, 1);
      chk("post_reset_validb", SEL_VB, 1);
      step();
    end

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 8 && q.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
